// File: rtl/bist_checker.sv
// Receive-side BIST response checker: regenerates the LFSR byte stream, compares
// each received byte, counts mismatches and reports pass/fail on completion or stall.
module bist_checker #(
  parameter int          NUM_BYTES      = 16,
  parameter logic [7:0]  SEED           = 8'h01,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timed_out,
  output logic [7:0] err_count,
  output logic [7:0] byte_count,
  output logic [7:0] first_err_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0]  LAST_IDX   = 8'(NUM_BYTES - 1);
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  expected;
  logic [7:0]  lfsr_next;
  logic [7:0]  err_q;
  logic [7:0]  byte_q;
  logic [7:0]  first_q;
  logic [15:0] idle_cnt;
  logic        timed_out_q;

  logic accept;
  logic launch;
  logic mismatch;
  logic last_byte;
  logic idle_expire;

  // Handshake: a byte is consumed on every rising edge where rx_valid=1 in RUN;
  // there is no ready, so the sender may stream one byte per cycle.
  assign accept      = (state == ST_RUN) && rx_valid;
  assign launch      = start && (state != ST_RUN);
  assign mismatch    = (rx_data != expected);
  assign last_byte   = (byte_q == LAST_IDX);
  assign idle_expire = (state == ST_RUN) && !rx_valid && (idle_cnt == IDLE_LIMIT);

  // x^8+x^6+x^5+x^4+1, Fibonacci form
  assign lfsr_next = {expected[6:0], expected[7] ^ expected[5] ^ expected[4] ^ expected[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if ((accept && last_byte) || idle_expire) state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
    pass = done && (err_q == 8'd0) && !timed_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      expected    <= SEED;
      err_q       <= 8'd0;
      byte_q      <= 8'd0;
      first_q     <= 8'd0;
      idle_cnt    <= 16'd0;
      timed_out_q <= 1'b0;
    end else if (accept) begin
      if (mismatch) begin
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        if (err_q == 8'd0)  first_q <= byte_q;
      end
      byte_q   <= byte_q + 8'd1;
      expected <= lfsr_next;
      idle_cnt <= 16'd0;
    end else if (state == ST_RUN) begin
      if (idle_expire) begin
        timed_out_q <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

  assign timed_out     = timed_out_q;
  assign err_count     = err_q;
  assign byte_count    = byte_q;
  assign first_err_idx = first_q;

endmodule

// File: doc/bist_checker.md
# bist_checker

Receive-side response checker for the built-in self-test path. While the transmit-side input selector drives pseudo-random BIST bytes into the link, this block sits after the receiver. It regenerates the same byte sequence, compares each received byte against it, counts mismatches, and reports pass or fail once a programmed number of bytes has arrived or the link stalls.

## Interface
Parameters:
- NUM_BYTES, default 16: bytes per test run; legal range 1..255.
- SEED, default 8'h01: LFSR seed; must equal the transmit-side generator seed; must be non-zero.
- TIMEOUT_CYCLES, default 1024: consecutive RUN cycles without rx_valid before the run aborts; legal range 2..65535.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse; begins a run from IDLE or DONE.
- rx_data, input, 8: received byte.
- rx_valid, input, 1: rx_data valid this cycle; one byte per high cycle.
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE; level, not pulse.
- pass, output, 1: valid when done=1; 1 = all bytes matched and no timeout.
- timed_out, output, 1: run ended by timeout.
- err_count, output, 8: mismatching bytes this run; saturates at 255.
- byte_count, output, 8: bytes accepted this run.
- first_err_idx, output, 8: 0-based index of the first mismatch; meaningful only when err_count≠0.

## Operation
- Expected-pattern LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - feedback = q[7]^q[5]^q[4]^q[3]; next = {q[6:0], feedback}.
  - From 8'h01 the sequence is 01, 02, 04, 08, 11, 23, …
- FSM states: IDLE, RUN, DONE.
- IDLE: start → RUN. Entry actions: expected←SEED; err_count, byte_count, first_err_idx, idle counter and timed_out cleared.
- RUN: on each rx_valid:
  - compare rx_data with expected.
  - On mismatch, err_count increments (saturating at 255). If err_count was 0, first_err_idx←byte_count.
  - byte_count increments; expected advances one LFSR step; idle counter clears.
- RUN exits:
  - Complete: the accepted byte makes byte_count reach NUM_BYTES → DONE.
  - Timeout: idle counter reaches TIMEOUT_CYCLES with no rx_valid → DONE, timed_out←1.
- DONE: pass = (err_count==0) && !timed_out, with the final byte's comparison included. Outputs hold until start (restart with full clear, as from IDLE) or rst.
- start while in RUN: ignored.
- rx_valid in IDLE or DONE: ignored; no counter or LFSR change.
- rst at any time, including mid-run: next cycle is IDLE and all state is cleared.

## Timing
- Reset values: state IDLE, busy=0, done=0, pass=0, timed_out=0, err_count=0, byte_count=0, first_err_idx=0, expected=SEED, idle counter=0.
- start sampled at edge N → busy=1 from N+1. A byte with rx_valid=1 in cycle N+1 is the first compared.
- Byte compare and count update: 1-cycle latency. Counters reflect byte k in the cycle after it is accepted.
- The last byte accepted at edge M → done=1, busy=0, pass valid from M+1.
- Timeout: the idle counter increments on each RUN cycle with rx_valid=0. When it reaches TIMEOUT_CYCLES-1 and rx_valid=0 again, DONE is entered on that edge.
- rx_valid on the same cycle the timeout would fire: the byte is accepted, the counter clears, and there is no timeout.
- Back-to-back rx_valid is supported at 1 byte per cycle with no stall.
- Output stability: outputs change only on clk edges.

## Test plan
- Clean run: NUM_BYTES=4, SEED=01; start, then send 01, 02, 04, 08 on consecutive cycles.
  - Required: done=1 one cycle after the 4th byte, pass=1, err_count=0, byte_count=4.
- Single error: send 01, 02, FF, 08.
  - Required: pass=0, err_count=1, first_err_idx=2. The LFSR keeps advancing, so 08 still matches.
- Timeout: TIMEOUT_CYCLES=8; start, send 01, then hold rx_valid=0.
  - Required: timed_out=1, done=1, pass=0, byte_count=1, with DONE entered 8 idle cycles after the byte.
- Gaps and ignored inputs:
  - Send rx_valid=1 in IDLE; then start and send bytes with 3-cycle gaps; assert start mid-run.
  - Required: the IDLE byte and mid-run start have no effect; the run passes.
- Saturation and restart:
  - NUM_BYTES=255 with every byte wrong → err_count=255, first_err_idx=0.
  - Then start from DONE with correct data → all counters cleared and pass=1.
- Reset mid-run: assert rst after 2 bytes.
  - Required: the next cycle shows all outputs at reset values. A subsequent run starts again from expected=01.
